// File: rtl/data_mem_responder.sv
// Word-addressed 32-bit data memory answering one request at a time; response LATENCY edges after acceptance.
// No backpressure: new requests are ignored while busy, next acceptance LATENCY+2 edges after the previous one.
module data_mem_responder #(
    parameter int LATENCY = 2,
    parameter int AW      = 6
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_err,
    output logic        o_busy
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] LP_CNT_INIT = 4'(LATENCY - 1);
    localparam int         LP_DEPTH    = 2 ** AW;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic            r_we;
    logic            r_misal;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic [31:0]     r_mem [LP_DEPTH];
    logic            w_access;
    logic            w_unused_addr_hi;

    // Upper byte-address bits fold away: the word index wraps modulo the depth.
    assign w_unused_addr_hi = ^i_addr[31:AW+2];

    assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_req) w_state_nxt = WAIT;
            WAIT:    if (r_cnt == 4'd0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_misal <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < LP_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && i_req) begin
                r_we    <= i_we;
                r_misal <= |i_addr[1:0];
                r_idx   <= i_addr[AW+1:2];
                r_wdata <= i_wdata;
                r_cnt   <= LP_CNT_INIT;
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Misaligned accesses fault without touching storage; writes return zero data.
            if (w_access) begin
                r_err <= r_misal;
                if (r_misal || r_we) begin
                    r_rdata <= '0;
                end else begin
                    r_rdata <= r_mem[r_idx];
                end
                if (!r_misal && r_we) begin
                    r_mem[r_idx] <= r_wdata;
                end
            end
        end
    end

    assign o_rdata = r_rdata;
    assign o_err   = r_err;
    assign o_ready = (r_state == DONE);
    assign o_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: per-cycle transaction-level model plus directed scenarios with literal expectations.
module tb_data_mem_responder;

    localparam int LAT = 2;
    localparam int AW  = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    int tests = 0;
    int fails = 0;

    data_mem_responder #(.LATENCY(LAT), .AW(AW)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_we    (we),
        .i_addr  (addr),
        .i_wdata (wdata),
        .o_rdata (rdata),
        .o_ready (ready),
        .o_err   (err),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model: one outstanding transaction, remembered by the edge number it was accepted on.
    logic [31:0] m_mem [2**AW];
    int          edge_n  = 0;
    int          acc_edge = 0;
    bit          pending = 1'b0;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    bit          m_err = 1'b0;
    bit          exp_ready;
    bit          exp_busy;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            pending = 1'b0;
            m_rdata = '0;
            m_err   = 1'b0;
            for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
        end else if (pending) begin
            if (edge_n == acc_edge + LAT) begin
                m_err = (m_addr % 4) != 0;
                if (m_err || m_we) m_rdata = '0;
                else m_rdata = m_mem[(m_addr / 4) % (2**AW)];
                if (!m_err && m_we) m_mem[(m_addr / 4) % (2**AW)] = m_wdata;
            end
            if (edge_n == acc_edge + LAT + 1) pending = 1'b0;
        end else if (req) begin
            pending  = 1'b1;
            acc_edge = edge_n;
            m_we     = we;
            m_addr   = addr;
            m_wdata  = wdata;
        end
        exp_ready = pending && (edge_n == acc_edge + LAT);
        exp_busy  = pending;
        #1;
        chk("ready", {31'd0, ready}, {31'd0, exp_ready});
        chk("busy",  {31'd0, busy},  {31'd0, exp_busy});
        if (exp_ready) begin
            chk("rdata", rdata, m_rdata);
            chk("err",   {31'd0, err}, {31'd0, m_err});
        end
    end

    // Issue one request from IDLE and wait (bounded) for its response strobe.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
        bit got;
        got = 1'b0;
        rd  = 'x;
        er  = 1'bx;
        lat = -1;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'hA5A5_A5A5;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                got = 1'b1;
                rd  = rdata;
                er  = err;
                lat = k;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL xact_timeout actual=no_ready expected=ready addr=%h", a);
        end else begin
            @(posedge clk);
            #1;
            chk("ready_width", {31'd0, ready}, 32'd0);
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          pulses;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err",   {31'd0, err},   32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        @(negedge clk);
        rst = 1'b0;

        xact(1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("rd10_lat",   lat, LAT);
        chk("rd10_rdata", rd, 32'h0000_0000);
        chk("rd10_err",   {31'd0, er}, 32'd0);

        xact(1'b1, 32'h24, 32'hDEAD_BEEF, rd, er, lat);
        chk("wr24_rdata", rd, 32'h0);
        chk("wr24_err",   {31'd0, er}, 32'd0);
        xact(1'b0, 32'h24, 32'h0, rd, er, lat);
        chk("rd24_rdata", rd, 32'hDEAD_BEEF);
        chk("rd24_err",   {31'd0, er}, 32'd0);

        xact(1'b1, 32'h100, 32'h1234_5678, rd, er, lat);
        xact(1'b1, 32'h102, 32'h1111_1111, rd, er, lat);
        chk("mis_wr_err",   {31'd0, er}, 32'd1);
        chk("mis_wr_rdata", rd, 32'h0);
        xact(1'b0, 32'h100, 32'h0, rd, er, lat);
        chk("rd100_rdata", rd, 32'h1234_5678);
        xact(1'b0, 32'h25, 32'h0, rd, er, lat);
        chk("mis_rd_err",   {31'd0, er}, 32'd1);
        chk("mis_rd_rdata", rd, 32'h0);

        xact(1'b1, 32'h04, 32'hCAFE_F00D, rd, er, lat);
        xact(1'b0, 32'h104, 32'h0, rd, er, lat);
        chk("wrap_rdata", rd, 32'hCAFE_F00D);

        // req held high: accepts at edges 1,5,9,13 -> responses after edges 3,7,11,15
        pulses = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h24;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (ready) pulses++;
        end
        @(negedge clk);
        req = 1'b0;
        chk("cont_pulses", pulses, 32'd4);
        repeat (LAT + 2) @(posedge clk);

        xact(1'b1, 32'h08, 32'h0000_0055, rd, er, lat);
        xact(1'b0, 32'h08, 32'h0, rd, er, lat);
        chk("rd08_pre", rd, 32'h0000_0055);

        // Reset mid-WAIT aborts a write.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h0C; wdata = 32'h0000_0077;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", {31'd0, ready}, 32'd0);
        chk("abort_busy",  {31'd0, busy},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        xact(1'b0, 32'h08, 32'h0, rd, er, lat);
        chk("rd08_post_rst", rd, 32'h0);
        xact(1'b0, 32'h0C, 32'h0, rd, er, lat);
        chk("rd0c_aborted", rd, 32'h0);

        repeat (2) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-002 Parameter AW, default 6, word-address width; storage depth 2**AW 32-bit words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  1  access request from the datapath, sampled only in IDLE.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  32  byte address; sampled with req.
REQ-008 wdata  input  32  write data; sampled with req.
REQ-009 rdata  output  32  read data; valid only while ready=1.
REQ-010 ready  output  1  one-cycle response strobe.
REQ-011 err  output  1  access fault indicator; valid only while ready=1.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-014 IDLE: req=1 at a rising edge SHALL latch we, addr, wdata, load the counter with LATENCY-1 and move to WAIT; req=0 keeps IDLE.
REQ-015 WAIT: counter nonzero SHALL decrement by 1 and stay in WAIT; counter zero SHALL perform the access and move to DONE.
REQ-016 DONE: ready=1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-017 Latency: req sampled at edge t SHALL make ready=1 in the cycle following edge t+LATENCY.
REQ-018 req, we, addr, wdata SHALL be ignored in WAIT and DONE; the earliest next acceptance is the edge leaving DONE+1 (back-to-back spacing LATENCY+2 edges).
REQ-019 Word index SHALL be latched addr[AW+1:2]; addr bits above AW+1 SHALL be ignored (address wraps modulo 2**AW words).
REQ-020 Misaligned request (latched addr[1:0] != 0) SHALL produce err=1 and rdata=0 in DONE, and SHALL NOT modify storage.
REQ-021 Aligned write SHALL update the indexed word at the WAIT->DONE edge; rdata=0, err=0 in DONE.
REQ-022 Aligned read SHALL register the indexed word into rdata at the WAIT->DONE edge; err=0.
REQ-023 rdata and err SHALL hold their values outside DONE only until the next DONE; ready SHALL be 0 in IDLE and WAIT.
REQ-024 busy SHALL be 1 in WAIT and DONE, 0 in IDLE.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, ready=0, err=0, rdata=0, busy=0, counter=0, and clear every storage word to 0.
REQ-026 rst takes priority over all other inputs in any state; reset during WAIT SHALL abort the access with no storage write and no ready pulse.
REQ-027 First request is accepted at the first edge with rst=0 and req=1.

Verification
REQ-028 Reset, then read addr 0x10 with LATENCY=2 -> ready=1 two edges after acceptance, rdata=0x00000000, err=0.
REQ-029 Write 0xDEADBEEF to 0x24, then read 0x24 -> read response rdata=0xDEADBEEF, err=0, ready pulse exactly one cycle wide.
REQ-030 Write 0x11111111 to 0x102 (misaligned) -> err=1, rdata=0; subsequent read of 0x100 returns prior contents unchanged.
REQ-031 Write 0xCAFEF00D to 0x04, read 0x104 (AW=6, wraps) -> rdata=0xCAFEF00D.
REQ-032 req held high continuously -> accepts every LATENCY+2 edges; requests during WAIT/DONE produce no extra ready pulses.
REQ-033 Write 0x55 to 0x08 with rst=1 asserted mid-WAIT -> no ready pulse, busy=0 next cycle, read of 0x08 returns 0.
